// File: rtl/orb_wr_arbiter.sv
// orb_wr_arbiter
// Shares the single write port of the double-buffered orbit RAM between four
// stream packers (F1, F2, S1, S2). Writes are granted round-robin with a
// req/gnt handshake. Each granted word goes into the active page, and pages
// swap on frame sync. The read side always uses ~page.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   req[3:0]         write request per requester (bit0=F1 .. bit3=S2)
//   addr0..addr3     word address within page, per requester
//   data0..data3     orbit word, per requester
//   enMask[3:0]      requester enable; a masked requester is never granted
//   frameSync        one-cycle pulse requesting a page swap
//   gnt[3:0]         one-hot, one-cycle grant pulse
//   wAddr[AW:0]      RAM write address {page, addr}
//   orbWord[DW-1:0]  RAM write data
//   WE               RAM write enable
//   page             current write page
//   swapPulse        one-cycle pulse in the cycle after a page toggle
//   wordCnt[11:0]    words written into the current page, saturating at 4095
//   syncOvr          sticky: frameSync arrived while a swap was still pending
module orb_wr_arbiter #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [AW-1:0] addr3,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic [DW-1:0] data3,
    input  logic [3:0]    enMask,
    input  logic          frameSync,
    output logic [3:0]    gnt,
    output logic [AW:0]   wAddr,
    output logic [DW-1:0] orbWord,
    output logic          WE,
    output logic          page,
    output logic          swapPulse,
    output logic [11:0]   wordCnt,
    output logic          syncOvr
);

    typedef enum logic [0:0] {StArb, StWr} state_t;

    state_t        stateQ, stateD;
    logic [1:0]    ptrQ, ptrD;
    logic          swapPendQ, swapPendD;
    logic [3:0]    gntD;
    logic [AW:0]   wAddrD;
    logic [DW-1:0] orbWordD;
    logic          weD, pageD, swapPulseD, syncOvrD;
    logic [11:0]   wordCntD;

    logic [AW-1:0] addrArr [4];
    logic [DW-1:0] dataArr [4];
    logic [3:0]    eligible;
    logic          found;
    logic [1:0]    win;
    logic [1:0]    idx;

    assign addrArr[0] = addr0;
    assign addrArr[1] = addr1;
    assign addrArr[2] = addr2;
    assign addrArr[3] = addr3;
    assign dataArr[0] = data0;
    assign dataArr[1] = data1;
    assign dataArr[2] = data2;
    assign dataArr[3] = data3;

    assign eligible = req & enMask;

    // Round-robin search starting at ptr, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptrQ + 2'(i);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        stateD     = stateQ;
        ptrD       = ptrQ;
        swapPendD  = swapPendQ;
        gntD       = 4'b0000;
        wAddrD     = wAddr;
        orbWordD   = orbWord;
        weD        = 1'b0;
        pageD      = page;
        swapPulseD = 1'b0;
        wordCntD   = wordCnt;
        syncOvrD   = syncOvr;

        unique case (stateQ)
            StArb: begin
                if (swapPendQ) begin
                    // Swap wins over any grant so no word straddles two pages.
                    pageD      = ~page;
                    swapPendD  = 1'b0;
                    swapPulseD = 1'b1;
                    wordCntD   = 12'd0;
                end else if (found) begin
                    wAddrD    = {page, addrArr[win]};
                    orbWordD  = dataArr[win];
                    weD       = 1'b1;
                    gntD[win] = 1'b1;
                    ptrD      = win + 2'd1;
                    if (wordCnt != 12'hFFF) begin
                        wordCntD = wordCnt + 12'd1;
                    end
                    stateD = StWr;
                end
            end
            StWr: begin
                stateD = StArb;
            end
            default: begin
                stateD = StArb;
            end
        endcase

        // A sync arriving while one is still pending merges into it: one swap only.
        if (frameSync) begin
            if (swapPendQ) begin
                syncOvrD = 1'b1;
            end else begin
                swapPendD = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ    <= StArb;
            ptrQ      <= 2'd0;
            swapPendQ <= 1'b0;
            gnt       <= 4'b0000;
            wAddr     <= '0;
            orbWord   <= '0;
            WE        <= 1'b0;
            page      <= 1'b0;
            swapPulse <= 1'b0;
            wordCnt   <= 12'd0;
            syncOvr   <= 1'b0;
        end else begin
            stateQ    <= stateD;
            ptrQ      <= ptrD;
            swapPendQ <= swapPendD;
            gnt       <= gntD;
            wAddr     <= wAddrD;
            orbWord   <= orbWordD;
            WE        <= weD;
            page      <= pageD;
            swapPulse <= swapPulseD;
            wordCnt   <= wordCntD;
            syncOvr   <= syncOvrD;
        end
    end

endmodule

// File: tb/tb_orb_wr_arbiter.sv
// tb_orb_wr_arbiter
// Directed bench for orb_wr_arbiter: reset, round-robin, masking, swap
// priority, sync overrun and word-count saturation.
module tb_orb_wr_arbiter;

    localparam int AW = 11;
    localparam int DW = 12;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [AW-1:0] addr0, addr1, addr2, addr3;
    logic [DW-1:0] data0, data1, data2, data3;
    logic [3:0]    enMask;
    logic          frameSync;
    logic [3:0]    gnt;
    logic [AW:0]   wAddr;
    logic [DW-1:0] orbWord;
    logic          WE;
    logic          page;
    logic          swapPulse;
    logic [11:0]   wordCnt;
    logic          syncOvr;

    int checks = 0;
    int errors = 0;

    orb_wr_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr0     (addr0),
        .addr1     (addr1),
        .addr2     (addr2),
        .addr3     (addr3),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .enMask    (enMask),
        .frameSync (frameSync),
        .gnt       (gnt),
        .wAddr     (wAddr),
        .orbWord   (orbWord),
        .WE        (WE),
        .page      (page),
        .swapPulse (swapPulse),
        .wordCnt   (wordCnt),
        .syncOvr   (syncOvr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req       = 4'b0000;
        enMask    = 4'b1111;
        frameSync = 1'b0;
        addr0 = '0; addr1 = '0; addr2 = '0; addr3 = '0;
        data0 = '0; data1 = '0; data2 = '0; data3 = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        req   = 4'b0001;
        addr0 = 11'h155;
        data0 = 12'hA5A;
        step();
        checks++;
        if (WE !== 1'b1) begin
            errors++; $display("FAIL reset_pre_we got %b want 1", WE);
        end
        // Reset asserted while in WR.
        rst = 1'b0;
        #1;
        checks++;
        if ({gnt, wAddr, orbWord, WE, page, swapPulse, wordCnt, syncOvr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b wAddr=%h orbWord=%h WE=%b page=%b sp=%b cnt=%0d ovr=%b want all 0",
                     gnt, wAddr, orbWord, WE, page, swapPulse, wordCnt, syncOvr);
        end
        step();
        checks++;
        if (WE !== 1'b0 || gnt !== 4'b0000) begin
            errors++; $display("FAIL reset_hold got WE=%b gnt=%b want 0 0000", WE, gnt);
        end
        rst   = 1'b1;
        addr0 = 11'h2AA;
        data0 = 12'h123;
        step();
        checks++;
        if (WE !== 1'b1 || gnt !== 4'b0001 || wAddr !== {1'b0, 11'h2AA} || orbWord !== 12'h123
            || wordCnt !== 12'd1) begin
            errors++;
            $display("FAIL reset_first_grant got WE=%b gnt=%b wAddr=%h orbWord=%h cnt=%0d want 1 0001 2aa 123 1",
                     WE, gnt, wAddr, orbWord, wordCnt);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0]    expGnt [5];
        logic [AW-1:0] curAddr;
        logic [DW-1:0] curData;
        expGnt[0] = 4'b0001; expGnt[1] = 4'b0010; expGnt[2] = 4'b0100;
        expGnt[3] = 4'b1000; expGnt[4] = 4'b0001;
        do_reset();
        addr0 = 11'd10; addr1 = 11'd20; addr2 = 11'd30; addr3 = 11'd40;
        data0 = 12'h100; data1 = 12'h200; data2 = 12'h300; data3 = 12'h400;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            case (k % 4)
                0: begin curAddr = addr0; curData = data0; end
                1: begin curAddr = addr1; curData = data1; end
                2: begin curAddr = addr2; curData = data2; end
                default: begin curAddr = addr3; curData = data3; end
            endcase
            step();
            checks++;
            if (gnt !== expGnt[k] || WE !== 1'b1 || wAddr !== {1'b0, curAddr}
                || orbWord !== curData || wordCnt !== 12'(k + 1)) begin
                errors++;
                $display("FAIL rr_grant%0d got gnt=%b WE=%b wAddr=%h orbWord=%h cnt=%0d want %b 1 %h %h %0d",
                         k, gnt, WE, wAddr, orbWord, wordCnt, expGnt[k], {1'b0, curAddr}, curData, k + 1);
            end
            // Granted requester presents its next word.
            case (k % 4)
                0: begin addr0 = addr0 + 11'd1; data0 = data0 + 12'd1; end
                1: begin addr1 = addr1 + 11'd1; data1 = data1 + 12'd1; end
                2: begin addr2 = addr2 + 11'd1; data2 = data2 + 12'd1; end
                default: begin addr3 = addr3 + 11'd1; data3 = data3 + 12'd1; end
            endcase
            step();
            checks++;
            if (WE !== 1'b0 || gnt !== 4'b0000) begin
                errors++; $display("FAIL rr_gap%0d got WE=%b gnt=%b want 0 0000", k, WE, gnt);
            end
        end
        checks++;
        if (wordCnt !== 12'd5) begin
            errors++; $display("FAIL rr_count got %0d want 5", wordCnt);
        end
        req = 4'b0000;
    endtask

    task automatic test_masking();
        do_reset();
        enMask = 4'b1011;
        req    = 4'b0101;
        addr2  = 11'd77;
        data2  = 12'h777;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (gnt !== 4'b0001 || WE !== 1'b1) begin
                errors++; $display("FAIL mask_grant%0d got gnt=%b WE=%b want 0001 1", k, gnt, WE);
            end
            if (k == 2) enMask = 4'b1111;
            step();
        end
        step();
        checks++;
        if (gnt !== 4'b0100 || wAddr !== {1'b0, 11'd77} || orbWord !== 12'h777) begin
            errors++;
            $display("FAIL mask_unmask got gnt=%b wAddr=%h orbWord=%h want 0100 04d 777", gnt, wAddr, orbWord);
        end
        req = 4'b0000;
    endtask

    task automatic test_swap_priority();
        do_reset();
        req   = 4'b0010;
        addr1 = 11'h011;
        data1 = 12'hABC;
        step();
        checks++;
        if (gnt !== 4'b0010 || wAddr !== {1'b0, 11'h011} || wordCnt !== 12'd1) begin
            errors++; $display("FAIL swap_first got gnt=%b wAddr=%h cnt=%0d want 0010 011 1", gnt, wAddr, wordCnt);
        end
        addr1     = 11'h022;
        data1     = 12'hDEF;
        frameSync = 1'b1;
        step();
        frameSync = 1'b0;
        step();
        checks++;
        if (page !== 1'b1 || swapPulse !== 1'b1 || WE !== 1'b0 || gnt !== 4'b0000 || wordCnt !== 12'd0) begin
            errors++;
            $display("FAIL swap_cycle got page=%b sp=%b WE=%b gnt=%b cnt=%0d want 1 1 0 0000 0",
                     page, swapPulse, WE, gnt, wordCnt);
        end
        step();
        checks++;
        if (gnt !== 4'b0010 || WE !== 1'b1 || wAddr !== {1'b1, 11'h022} || orbWord !== 12'hDEF
            || wordCnt !== 12'd1 || swapPulse !== 1'b0 || page !== 1'b1) begin
            errors++;
            $display("FAIL swap_after got gnt=%b WE=%b wAddr=%h orbWord=%h cnt=%0d sp=%b page=%b want 0010 1 822 def 1 0 1",
                     gnt, WE, wAddr, orbWord, wordCnt, swapPulse, page);
        end
        req = 4'b0000;
    endtask

    task automatic test_overrun();
        do_reset();
        req = 4'b0001;
        step();
        req       = 4'b0000;
        frameSync = 1'b1;
        step();
        step();
        frameSync = 1'b0;
        checks++;
        if (page !== 1'b1 || swapPulse !== 1'b1 || syncOvr !== 1'b1) begin
            errors++; $display("FAIL ovr_swap got page=%b sp=%b ovr=%b want 1 1 1", page, swapPulse, syncOvr);
        end
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (page !== 1'b1 || swapPulse !== 1'b0 || syncOvr !== 1'b1) begin
            errors++; $display("FAIL ovr_single_toggle got page=%b sp=%b ovr=%b want 1 0 1", page, swapPulse, syncOvr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (syncOvr !== 1'b0 || page !== 1'b0) begin
            errors++; $display("FAIL ovr_clear got ovr=%b page=%b want 0 0", syncOvr, page);
        end
        rst = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        req   = 4'b0001;
        addr0 = 11'd5;
        for (int k = 0; k < 4100; k++) begin
            step();
            if (k == 4094 || k == 4099) begin
                checks++;
                if (wordCnt !== 12'd4095 || WE !== 1'b1) begin
                    errors++; $display("FAIL sat_grant%0d got cnt=%0d WE=%b want 4095 1", k, wordCnt, WE);
                end
            end
            step();
        end
        req       = 4'b0000;
        frameSync = 1'b1;
        step();
        frameSync = 1'b0;
        checks++;
        if (wordCnt !== 12'd4095) begin
            errors++; $display("FAIL sat_hold got %0d want 4095", wordCnt);
        end
        step();
        checks++;
        if (wordCnt !== 12'd0 || page !== 1'b1 || swapPulse !== 1'b1) begin
            errors++; $display("FAIL sat_clear got cnt=%0d page=%b sp=%b want 0 1 1", wordCnt, page, swapPulse);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_masking();
        test_swap_priority();
        test_overrun();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/orb_wr_arbiter.md
Name: orb_wr_arbiter

Overview:
- Shares the single write port of the double-buffered orbit RAM between four stream packers: fast F1, fast F2, slow S1, slow S2 (requester index 0..3).
- Grants writes round-robin with a req/gnt handshake.
- Maps each granted word into the active RAM page and swaps pages on the frame sync.
- Sits between the packers and the orbit RAM; the read side always uses the inactive page.

Parameters:
AW, 11, per-requester word address width (address within one page)
DW, 12, orbit word width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
req  in  4  write request per requester; bit0=F1, bit1=F2, bit2=S1, bit3=S2
addr0..addr3  in  AW each  word address within page, per requester
data0..data3  in  DW each  orbit word, per requester
enMask  in  4  requester enable; a masked requester is never granted
frameSync  in  1  one-cycle pulse; request a page swap
gnt  out  4  one-hot grant pulse, one cycle
wAddr  out  AW+1  RAM write address, {page, addr}
orbWord  out  DW  RAM write data
WE  out  1  RAM write enable, one cycle per granted word
page  out  1  current write page; the read side uses ~page
swapPulse  out  1  one-cycle pulse when page toggles
wordCnt  out  12  words written into current page; saturates at 4095
syncOvr  out  1  sticky: frameSync arrived while a swap was still pending

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low.
- Reset state: state=ARB, ptr=0, swapPend=0.
- Reset output values: gnt=0, wAddr=0, orbWord=0, WE=0, page=0, swapPulse=0, wordCnt=0, syncOvr=0. Reset mid-write drops that write; no gnt is issued for it.
- All outputs are registered.
- Requester rule: hold req high with stable addr/data until the cycle gnt[i] is high. On the edge that samples gnt[i]=1, either drop req or present the next word with req still high.
- State ARB:
  - Priority 1: if swapPend=1, then page<=~page, swapPend<=0, swapPulse<=1, wordCnt<=0. No grant this cycle; stay in ARB.
  - Priority 2: else if (req & enMask)!=0, pick winner w = first set bit searching ptr, ptr+1, ... modulo 4. Then wAddr<={page, addr_w}, orbWord<=data_w, WE<=1, gnt[w]<=1, ptr<=w+1 (mod 4), wordCnt<=wordCnt+1 unless already 4095. Go to WR.
  - Otherwise: WE=0, gnt=0; stay in ARB.
- State WR: WE<=0, gnt<=0, swapPulse<=0; go to ARB. req is not sampled in WR, so a requester's stale req is never double-granted.
- Latency: req sampled in ARB at edge N gives WE/gnt high in cycle N..N+1. Peak throughput is one write per 2 cycles. A lone requester holding req sees gnt every 2nd cycle.
- A write granted in the same ARB cycle as a page toggle cannot occur, because the swap has priority. Every word lands wholly in one page.
- frameSync handling:
  - frameSync in any state sets swapPend.
  - If swapPend is already 1 at that edge, set syncOvr. Only one swap still occurs.
  - syncOvr is cleared only by reset.
- enMask changes take effect at the next ARB sample. A masked requester keeps waiting and is not granted.
- ptr advances only on a grant; a swap cycle leaves ptr unchanged.
- wordCnt: 12-bit, saturates at 4095. It reflects the count after the last grant.
- swapPulse is high exactly one cycle, the cycle after the toggle edge. page is already updated in that cycle.

Test Plan:
- Reset check: rst low mid-WR -> all outputs 0; page=0. After release, the first ARB with req=0001 gives WE=1, gnt=0001, wAddr={0, addr0}.
- Round-robin: req=1111 held, each requester updates addr on its gnt -> gnt sequence 0001, 0010, 0100, 1000, 0001. WE high every 2nd cycle; wordCnt=5 after 5 grants.
- Masking: req=0101, enMask=1011 -> only gnt=0001 repeats. Drop bit2 of the mask -> gnt=0100 appears on the next ARB cycle after the previous grant.
- Swap priority: frameSync pulse during WR with req=0010 pending -> next ARB cycle gives page=1, swapPulse=1, WE=0, wordCnt=0. The following ARB grants requester 1 with wAddr={1, addr1}, wordCnt=1.
- Overrun: two frameSync pulses on consecutive cycles while in WR -> exactly one page toggle; syncOvr=1 and stays 1 until rst low.
- Saturation: 4100 grants on one page with no frameSync -> wordCnt=4095. frameSync -> wordCnt=0.
